// File: rtl/wireframe_sequencer.sv
// -----------------------------------------------------------------------------
// wireframe_sequencer
//
// Walks a parameterised edge list once per frame. For each edge it looks up
// both endpoints in a writable vertex table, adds a per-pass signed offset,
// and hands the line to draw_line over a start/done handshake.
//
// Optional feature macro: WIREFRAME_CLIP_EN
//   undefined : endpoints are (vertex + offset) wrapped modulo 2^COORD_W
//   defined   : endpoints are clamped to [0,H_MAX-1] x [0,V_MAX-1] and an
//               extra 'clipped' output reports that clamping took place
//
// Ports
//   clk, rst            pixel clock, synchronous active-high reset
//   en, frame           pass trigger (frame) gated by en
//   off_x, off_y        signed translation, captured when a pass starts
//   vert_we/addr/x/y    vertex table write port (any state)
//   x0, y0, x1, y1      current line endpoints (held through the handshake)
//   line_start          one-cycle request to draw_line
//   line_done           one-cycle completion from draw_line
//   busy                pass in progress
//   pass_done           one-cycle pulse after the last edge completes
//   overrun             sticky: a frame arrived while busy (cleared by rst)
//   clipped             (WIREFRAME_CLIP_EN only) current endpoints were clamped
// -----------------------------------------------------------------------------
module wireframe_sequencer #(
    parameter int COORD_W  = 11,
    parameter int VERT_CNT = 8,
    parameter int EDGE_CNT = 12,
    // Each entry is {second index, first index}; entry 0 in the LSBs.
    parameter logic [EDGE_CNT*2*$clog2(VERT_CNT)-1:0] EDGE_TABLE = {
        3'd7, 3'd3,  3'd6, 3'd2,  3'd5, 3'd1,  3'd4, 3'd0,
        3'd4, 3'd7,  3'd7, 3'd6,  3'd6, 3'd5,  3'd5, 3'd4,
        3'd0, 3'd3,  3'd3, 3'd2,  3'd2, 3'd1,  3'd1, 3'd0
    },
    parameter int H_MAX    = 800,
    parameter int V_MAX    = 600
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          frame,
    input  logic signed [COORD_W-1:0]     off_x,
    input  logic signed [COORD_W-1:0]     off_y,
    input  logic                          vert_we,
    input  logic [$clog2(VERT_CNT)-1:0]   vert_addr,
    input  logic [COORD_W-1:0]            vert_x,
    input  logic [COORD_W-1:0]            vert_y,
    output logic [COORD_W-1:0]            x0,
    output logic [COORD_W-1:0]            y0,
    output logic [COORD_W-1:0]            x1,
    output logic [COORD_W-1:0]            y1,
    output logic                          line_start,
    input  logic                          line_done,
    output logic                          busy,
    output logic                          pass_done,
    output logic                          overrun
`ifdef WIREFRAME_CLIP_EN
    ,
    output logic                          clipped
`endif
);

    localparam int IDX_W  = $clog2(VERT_CNT);
    localparam int EIDX_W = (EDGE_CNT > 1) ? $clog2(EDGE_CNT) : 1;
    localparam int SUM_W  = COORD_W + 2;
    localparam logic [EIDX_W-1:0] LAST_EDGE = EIDX_W'(EDGE_CNT - 1);

    // The visible window must be addressable by the coordinate width.
    if (H_MAX < 1 || V_MAX < 1 || H_MAX > (1 << COORD_W) || V_MAX > (1 << COORD_W))
    begin : g_bad_dims
        $error("wireframe_sequencer: H_MAX/V_MAX must fit in COORD_W bits");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Endpoint arithmetic
    // -------------------------------------------------------------------------
`ifdef WIREFRAME_CLIP_EN
    localparam logic signed [SUM_W-1:0] X_HI = SUM_W'(H_MAX - 1);
    localparam logic signed [SUM_W-1:0] Y_HI = SUM_W'(V_MAX - 1);

    // Unsigned vertex plus signed offset, wide enough never to overflow.
    function automatic logic signed [SUM_W-1:0] wide_add(
        input logic [COORD_W-1:0]        v,
        input logic signed [COORD_W-1:0] o
    );
        logic signed [SUM_W-1:0] r;
        r = $signed({2'b00, v}) + $signed({{2{o[COORD_W-1]}}, o});
        return r;
    endfunction

    // Returns {clamped_flag, value} with value in [0, hi].
    function automatic logic [COORD_W:0] clamp_axis(
        input logic signed [SUM_W-1:0] s,
        input logic signed [SUM_W-1:0] hi
    );
        logic [COORD_W:0] r;
        if (s[SUM_W-1]) begin
            r = {1'b1, {COORD_W{1'b0}}};
        end else if (s > hi) begin
            r = {1'b1, hi[COORD_W-1:0]};
        end else begin
            r = {1'b0, s[COORD_W-1:0]};
        end
        return r;
    endfunction
`else
    // Two's-complement wrap modulo 2^COORD_W.
    function automatic logic [COORD_W-1:0] wrap_add(
        input logic [COORD_W-1:0]        v,
        input logic signed [COORD_W-1:0] o
    );
        logic [COORD_W-1:0] r;
        r = v + $unsigned(o);
        return r;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Vertex table: never reset, written in any state. Reads are combinational
    // from the stored flops, so a same-cycle write is seen only by later LOADs.
    // -------------------------------------------------------------------------
    logic [COORD_W-1:0] vx_mem [VERT_CNT];
    logic [COORD_W-1:0] vy_mem [VERT_CNT];

    always_ff @(posedge clk) begin
        if (vert_we) begin
            vx_mem[vert_addr] <= vert_x;
            vy_mem[vert_addr] <= vert_y;
        end
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t                     state_q,      state_d;
    logic [EIDX_W-1:0]          edge_idx_q,   edge_idx_d;
    logic                       busy_q,       busy_d;
    logic                       pass_done_q,  pass_done_d;
    logic                       line_start_q, line_start_d;
    logic                       overrun_q,    overrun_d;
    logic [COORD_W-1:0]         x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0]         x0_d, y0_d, x1_d, y1_d;
    logic signed [COORD_W-1:0]  off_x_q, off_x_d;
    logic signed [COORD_W-1:0]  off_y_q, off_y_d;
`ifdef WIREFRAME_CLIP_EN
    logic                       clipped_q,    clipped_d;
`endif

    // Translated endpoints of the current edge (consumed only in LOAD).
    logic [IDX_W-1:0]   va_idx, vb_idx;
    logic [COORD_W-1:0] nx0, ny0, nx1, ny1;
`ifdef WIREFRAME_CLIP_EN
    logic               cx0, cy0, cx1, cy1;
`endif

    always_comb begin
        int base;
        base   = int'(edge_idx_q) * 2 * IDX_W;
        va_idx = EDGE_TABLE[base +: IDX_W];
        vb_idx = EDGE_TABLE[base + IDX_W +: IDX_W];
`ifdef WIREFRAME_CLIP_EN
        {cx0, nx0} = clamp_axis(wide_add(vx_mem[va_idx], off_x_q), X_HI);
        {cy0, ny0} = clamp_axis(wide_add(vy_mem[va_idx], off_y_q), Y_HI);
        {cx1, nx1} = clamp_axis(wide_add(vx_mem[vb_idx], off_x_q), X_HI);
        {cy1, ny1} = clamp_axis(wide_add(vy_mem[vb_idx], off_y_q), Y_HI);
`else
        nx0 = wrap_add(vx_mem[va_idx], off_x_q);
        ny0 = wrap_add(vy_mem[va_idx], off_y_q);
        nx1 = wrap_add(vx_mem[vb_idx], off_x_q);
        ny1 = wrap_add(vy_mem[vb_idx], off_y_q);
`endif
    end

    always_comb begin
        state_d      = state_q;
        edge_idx_d   = edge_idx_q;
        busy_d       = busy_q;
        pass_done_d  = 1'b0;
        line_start_d = 1'b0;
        // busy is still high in the DONE cycle, so a frame there is an overrun.
        overrun_d    = overrun_q | (frame & busy_q);
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        off_x_d      = off_x_q;
        off_y_d      = off_y_q;
`ifdef WIREFRAME_CLIP_EN
        clipped_d    = clipped_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (frame && en) begin
                    state_d    = S_LOAD;
                    off_x_d    = off_x;
                    off_y_d    = off_y;
                    edge_idx_d = '0;
                    busy_d     = 1'b1;
                end
            end
            S_LOAD: begin
                x0_d         = nx0;
                y0_d         = ny0;
                x1_d         = nx1;
                y1_d         = ny1;
`ifdef WIREFRAME_CLIP_EN
                clipped_d    = cx0 | cy0 | cx1 | cy1;
`endif
                // Registered so the request coincides with the ISSUE cycle.
                line_start_d = 1'b1;
                state_d      = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (line_done) begin
                    if (edge_idx_q == LAST_EDGE) begin
                        state_d = S_DONE;
                    end else begin
                        edge_idx_d = edge_idx_q + 1'b1;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                pass_done_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            edge_idx_q   <= '0;
            busy_q       <= 1'b0;
            pass_done_q  <= 1'b0;
            line_start_q <= 1'b0;
            overrun_q    <= 1'b0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
`ifdef WIREFRAME_CLIP_EN
            clipped_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            edge_idx_q   <= edge_idx_d;
            busy_q       <= busy_d;
            pass_done_q  <= pass_done_d;
            line_start_q <= line_start_d;
            overrun_q    <= overrun_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
`ifdef WIREFRAME_CLIP_EN
            clipped_q    <= clipped_d;
`endif
        end
        // Offsets are only meaningful after a pass start, which loads them.
        off_x_q <= off_x_d;
        off_y_q <= off_y_d;
    end

    assign x0         = x0_q;
    assign y0         = y0_q;
    assign x1         = x1_q;
    assign y1         = y1_q;
    assign line_start = line_start_q;
    assign busy       = busy_q;
    assign pass_done  = pass_done_q;
    assign overrun    = overrun_q;
`ifdef WIREFRAME_CLIP_EN
    assign clipped    = clipped_q;
`endif

endmodule

// File: tb/tb_wireframe_sequencer.sv
module tb_wireframe_sequencer;

    localparam int CW = 11;
    localparam int VC = 8;
    localparam int EC = 12;
    localparam int HM = 800;
    localparam int VM = 600;

    logic                 clk = 1'b0;
    logic                 rst, en, frame, vert_we, line_done;
    logic [2:0]           vert_addr;
    logic [CW-1:0]        vert_x, vert_y;
    logic signed [CW-1:0] off_x, off_y;
    logic [CW-1:0]        x0, y0, x1, y1;
    logic                 line_start, busy, pass_done, overrun;
`ifdef WIREFRAME_CLIP_EN
    logic                 clipped;
`endif

    always #5 clk = ~clk;

    wireframe_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .frame(frame),
        .off_x(off_x), .off_y(off_y),
        .vert_we(vert_we), .vert_addr(vert_addr), .vert_x(vert_x), .vert_y(vert_y),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .line_start(line_start), .line_done(line_done),
        .busy(busy), .pass_done(pass_done), .overrun(overrun)
`ifdef WIREFRAME_CLIP_EN
        , .clipped(clipped)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int EA[EC] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
    int EB[EC] = '{1, 2, 3, 0, 5, 6, 7, 4, 4, 5, 6, 7};
    int mvx[VC], mvy[VC];
    int m_offx, m_offy, mk;
    bit m_busy = 0, m_ov = 0, m_wait = 0, ecl = 0;
    int load_at = -1, ls_at = -1, pd_at = -1, cyc = 0;
    logic [CW-1:0] ex0 = '0, ey0 = '0, ex1 = '0, ey1 = '0;
    bit chk_en = 0;

    // Position of one endpoint coordinate after translation.
    function automatic int place(input int v, input int o, input int hi, output bit c);
        int s;
        s = v + o;
        c = 1'b0;
`ifdef WIREFRAME_CLIP_EN
        if (s < 0) begin c = 1'b1; return 0; end
        if (s > hi - 1) begin c = 1'b1; return hi - 1; end
        return s;
`else
        return s & ((1 << CW) - 1);
`endif
    endfunction

    // Timing rules: frame at N -> endpoints loaded in N+1, line_start at N+2;
    // line_done accepted only after the line_start cycle; the next edge loads
    // the cycle after line_done; pass_done/busy-drop 2 cycles after last done.
    always @(posedge clk) begin : model
        bit busy_now, c0, c1, c2, c3;
        busy_now = m_busy;
        if (!rst && cyc == load_at) begin
            ex0 = CW'(place(mvx[EA[mk]], m_offx, HM, c0));
            ey0 = CW'(place(mvy[EA[mk]], m_offy, VM, c1));
            ex1 = CW'(place(mvx[EB[mk]], m_offx, HM, c2));
            ey1 = CW'(place(mvy[EB[mk]], m_offy, VM, c3));
            ecl = c0 | c1 | c2 | c3;
            ls_at = cyc + 1;
        end
        if (vert_we) begin
            mvx[vert_addr] = int'(vert_x);
            mvy[vert_addr] = int'(vert_y);
        end
        if (rst) begin
            m_busy = 0; m_ov = 0; m_wait = 0; ecl = 0;
            ex0 = '0; ey0 = '0; ex1 = '0; ey1 = '0;
            load_at = -1; ls_at = -1; pd_at = -1; mk = 0;
        end else begin
            if (frame && busy_now) m_ov = 1;
            if (m_wait && line_done) begin
                m_wait = 0;
                if (mk == EC - 1) pd_at = cyc + 2;
                else begin mk++; load_at = cyc + 1; end
            end
            if (cyc == ls_at) m_wait = 1;
            if (cyc + 1 == pd_at) m_busy = 0;
            if (!busy_now && frame && en) begin
                m_busy = 1;
                m_offx = int'(off_x);
                m_offy = int'(off_y);
                mk = 0;
                load_at = cyc + 1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("x0", int'(x0), int'(ex0));
            check("y0", int'(y0), int'(ey0));
            check("x1", int'(x1), int'(ex1));
            check("y1", int'(y1), int'(ey1));
            check("line_start", int'(line_start), int'(ls_at == cyc));
            check("pass_done", int'(pass_done), int'(pd_at == cyc));
            check("busy", int'(busy), int'(m_busy));
            check("overrun", int'(overrun), int'(m_ov));
`ifdef WIREFRAME_CLIP_EN
            check("clipped", int'(clipped), int'(ecl));
`endif
        end
    end

    // ---------------- stimulus ----------------
    int done_timer = 0, fixed_delay = 5, tcyc = 0, last_done_cyc = 0, pd_seen_cyc = 0;
    bit rnd_delay = 0, spur_en = 0, rnd_mode = 0;
    int qx0[$], qy0[$], qx1[$], qy1[$], qcl[$];

    task automatic tick();
        @(posedge clk);
        #2;
        tcyc++;
        line_done = 1'b0;
        if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) begin line_done = 1'b1; last_done_cyc = tcyc; end
        end
        if (spur_en && $urandom_range(0, 15) == 0) line_done = 1'b1;
        if (line_start) begin
            done_timer = rnd_delay ? int'($urandom_range(1, 6)) : fixed_delay;
            qx0.push_back(int'(x0)); qy0.push_back(int'(y0));
            qx1.push_back(int'(x1)); qy1.push_back(int'(y1));
`ifdef WIREFRAME_CLIP_EN
            qcl.push_back(int'(clipped));
`else
            qcl.push_back(0);
`endif
        end
        if (pass_done) pd_seen_cyc = tcyc;
        if (rnd_mode) begin
            vert_we   = ($urandom_range(0, 3) == 0);
            vert_addr = 3'($urandom_range(0, 7));
            vert_x    = CW'($urandom_range(0, 2047));
            vert_y    = CW'($urandom_range(0, 2047));
            frame     = ($urandom_range(0, 40) == 0);
            en        = ($urandom_range(0, 3) != 0);
            off_x     = CW'($urandom);
            off_y     = CW'($urandom);
            rst       = ($urandom_range(0, 599) == 0);
        end
    endtask

    task automatic clear_q();
        qx0.delete(); qy0.delete(); qx1.delete(); qy1.delete(); qcl.delete();
    endtask

    task automatic write_vert(input int a, input int x, input int y);
        vert_we = 1'b1; vert_addr = 3'(a); vert_x = CW'(x); vert_y = CW'(y);
        tick();
        vert_we = 1'b0;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    // Starts a pass and checks that line_start follows the frame by 2 cycles.
    task automatic start_pass(input string name);
        int n;
        pulse_frame();
        n = 1;
        while (!line_start && n < 10) begin tick(); n++; end
        check(name, n, 2);
    endtask

    task automatic wait_pass(input int budget);
        int n;
        n = 0;
        while (!pass_done && n < budget) begin tick(); n++; end
        if (!pass_done) check("pass_timeout", 0, 1);
    endtask

    task automatic wait_lines(input int cnt, input int budget);
        int n;
        n = 0;
        while (qx0.size() < cnt && n < budget) begin tick(); n++; end
        if (qx0.size() < cnt) check("lines_timeout", qx0.size(), cnt);
    endtask

    int cube_x[VC] = '{200, 400, 400, 200, 100, 300, 300, 100};
    int cube_y[VC] = '{200, 200, 400, 400, 100, 100, 300, 300};

    initial begin
        bit c;
        rst = 1'b1; en = 1'b0; frame = 1'b0; vert_we = 1'b0; line_done = 1'b0;
        vert_addr = '0; vert_x = '0; vert_y = '0; off_x = '0; off_y = '0;
        repeat (3) tick();
        chk_en = 1;
        check("rst_busy", int'(busy), 0);
        check("rst_line_start", int'(line_start), 0);
        check("rst_x0", int'(x0), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        // Pin the model's arithmetic against hand-computed values.
        check("model_add", place(200, 10, HM, c), 210);
        check("model_sub", place(200, -20, VM, c), 180);
`ifdef WIREFRAME_CLIP_EN
        check("model_clip_lo", place(5, -10, HM, c), 0);
        check("model_clip_hi", place(795, 10, HM, c), 799);
`else
        check("model_wrap", place(5, -10, HM, c), 2043);
`endif

        for (int i = 0; i < VC; i++) write_vert(i, cube_x[i], cube_y[i]);

        // Cube, no offset.
        en = 1'b1; off_x = '0; off_y = '0; fixed_delay = 5;
        clear_q();
        start_pass("latency_a");
        wait_pass(400);
        check("lines_a", qx0.size(), 12);
        check("first_x0", qx0[0], 200); check("first_y0", qy0[0], 200);
        check("first_x1", qx1[0], 400); check("first_y1", qy1[0], 200);
        check("last_x0", qx0[11], 200); check("last_y0", qy0[11], 400);
        check("last_x1", qx1[11], 100); check("last_y1", qy1[11], 300);
        check("pass_done_lag", pd_seen_cyc - last_done_cyc, 2);
        repeat (3) tick();

        // Offset pass; offsets change mid-pass and must not matter.
        off_x = 11'sd10; off_y = -11'sd20;
        clear_q();
        start_pass("latency_b");
        repeat (3) tick();
        off_x = -11'sd300; off_y = 11'sd77;
        wait_pass(400);
        check("lines_b", qx0.size(), 12);
        check("off_x0", qx0[0], 210); check("off_y0", qy0[0], 180);
        check("off_x1", qx1[0], 410); check("off_y1", qy1[0], 180);
        check("off2_x1", qx1[1], 410); check("off2_y1", qy1[1], 380);
        repeat (3) tick();

        // Frame during WAIT of edge 3.
        off_x = '0; off_y = '0;
        clear_q();
        start_pass("latency_c");
        wait_lines(4, 200);
        tick();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check("overrun_set", int'(overrun), 1);
        wait_pass(400);
        check("lines_c", qx0.size(), 12);
        repeat (5) tick();
        check("overrun_sticky", int'(overrun), 1);
        check("busy_after_c", int'(busy), 0);

        // Reset during WAIT of edge 5; the pending line_done lands afterwards.
        clear_q();
        start_pass("latency_d");
        wait_lines(6, 200);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_overrun", int'(overrun), 0);
        check("rst_mid_x0", int'(x0), 0);
        repeat (8) tick();
        clear_q();
        start_pass("latency_after_rst");
        check("rst_first_x0", qx0[0], 200);
        check("rst_first_y1", qy1[0], 200);
        wait_pass(400);
        check("lines_d", qx0.size(), 12);
        repeat (3) tick();

        // Boundary arithmetic.
        write_vert(0, 5, 5);
        write_vert(1, 795, 5);
        off_x = -11'sd10; off_y = '0;
        clear_q();
        start_pass("latency_e");
        wait_pass(400);
`ifdef WIREFRAME_CLIP_EN
        check("clip_x0", qx0[0], 0);
        check("clip_flag", qcl[0], 1);
`else
        check("wrap_x0", qx0[0], 2043);
`endif
        check("neg_x1", qx1[0], 785);
        repeat (2) tick();
        off_x = 11'sd10;
        clear_q();
        start_pass("latency_f");
        wait_pass(400);
        check("pos_x0", qx0[0], 15);
`ifdef WIREFRAME_CLIP_EN
        check("clip_x1", qx1[0], 799);
        check("clip_flag2", qcl[0], 1);
`else
        check("big_x1", qx1[0], 805);
`endif
        repeat (2) tick();

        // en low: frames and spurious line_done are ignored.
        en = 1'b0;
        clear_q();
        spur_en = 1;
        for (int i = 0; i < 5; i++) begin
            pulse_frame();
            repeat (6) tick();
        end
        spur_en = 0;
        check("en0_lines", qx0.size(), 0);
        check("en0_busy", int'(busy), 0);

        // Randomised traffic.
        rnd_mode = 1; rnd_delay = 1; spur_en = 1;
        repeat (4000) tick();
        rnd_mode = 0; spur_en = 0;
        rst = 1'b0; frame = 1'b0; vert_we = 1'b0;
        repeat (80) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
